// File: rtl/microprogram_sequencer.sv
// -----------------------------------------------------------------------------
// microprogram_sequencer
//
// Purpose:
//   Steps a microprogram counter through a small writable control store and
//   emits one control word per cycle toward the lab datapath.  The host loads
//   microinstructions through the cfg_* port while the sequencer is not
//   running, pulses start, and waits for done.  Branches can depend on the
//   condition inputs x1/x2 or on an internal loop counter (LDC / DJNZ).
//
// Microinstruction layout, MSB first:
//   ctrl[CTRL_W] | cond[3] | br[ADDR_W] | end[1]
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset (clears store, counters, FSM)
//   start     in   run request, honoured in IDLE only
//   abort     in   terminate the current run (RUN only), no done pulse
//   x1, x2    in   branch conditions, sampled on the edge ending an instruction
//   cfg_we    in   control-store write enable
//   cfg_addr  in   control-store write address
//   cfg_data  in   control-store write data (one full microinstruction)
//   busy      out  high while a program is executing
//   done      out  one-cycle pulse after the end instruction has executed
//   cfg_err   out  one-cycle pulse following a write attempted during a run
//   upc       out  microprogram counter
//   ctrl      out  control word driven to the datapath
// -----------------------------------------------------------------------------
module microprogram_sequencer #(
  parameter  int ADDR_W = 4,
  parameter  int CTRL_W = 8,
  parameter  int LOOP_W = 8,
  localparam int W      = CTRL_W + 3 + ADDR_W + 1,
  localparam int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              x1,
  input  logic              x2,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [W-1:0]      cfg_data,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [ADDR_W-1:0] upc,
  output logic [CTRL_W-1:0] ctrl
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Branch condition codes
  localparam logic [2:0] COND_NEXT  = 3'd0;
  localparam logic [2:0] COND_JMP   = 3'd1;
  localparam logic [2:0] COND_X1    = 3'd2;
  localparam logic [2:0] COND_NX1   = 3'd3;
  localparam logic [2:0] COND_X2    = 3'd4;
  localparam logic [2:0] COND_NX2   = 3'd5;
  localparam logic [2:0] COND_DJNZ  = 3'd6;
  localparam logic [2:0] COND_LDC   = 3'd7;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] upc_q, upc_d;
  logic [LOOP_W-1:0] cnt_q, cnt_d;
  logic              cfg_err_q, cfg_err_d;

  // Register-based store: it must clear on reset and be read combinationally
  // at upc, so it cannot map onto a registered-read block RAM.
  logic [W-1:0]      mem_q [DEPTH];

  // Fields of the instruction currently addressed by upc
  logic [W-1:0]      cur_word;
  logic [CTRL_W-1:0] cur_ctrl;
  logic [2:0]        cur_cond;
  logic [ADDR_W-1:0] cur_br;
  logic              cur_end;
  logic [ADDR_W-1:0] upc_inc;
  logic              take_br;
  logic              running;
  logic              store_wr;

  assign cur_word = mem_q[upc_q];
  assign cur_ctrl = cur_word[W-1 -: CTRL_W];
  assign cur_cond = cur_word[ADDR_W+3 -: 3];
  assign cur_br   = cur_word[ADDR_W -: ADDR_W];
  assign cur_end  = cur_word[0];

  // Natural wrap from the top address back to 0 is intended
  assign upc_inc  = upc_q + ADDR_W'(1);

  assign running  = (state_q == ST_RUN);
  // Writes are only accepted while the program is not being fetched
  assign store_wr = cfg_we && !running;

  // ---------------------------------------------------------------------------
  // Next-state / sequencing logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    upc_d     = upc_q;
    cnt_d     = cnt_q;
    take_br   = 1'b0;
    cfg_err_d = cfg_we && running;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          upc_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // abort outranks end; in both cases upc keeps its value
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cur_end) begin
          state_d = ST_DONE;
        end else begin
          case (cur_cond)
            COND_NEXT: take_br = 1'b0;
            COND_JMP:  take_br = 1'b1;
            COND_X1:   take_br = x1;
            COND_NX1:  take_br = !x1;
            COND_X2:   take_br = x2;
            COND_NX2:  take_br = !x2;
            COND_DJNZ: begin
              if (cnt_q != '0) begin
                cnt_d   = cnt_q - LOOP_W'(1);
                take_br = 1'b1;
              end
            end
            COND_LDC: begin
              // The loop count shares the ctrl field; ctrl output is
              // masked for this instruction so the datapath never sees it.
              cnt_d = cur_ctrl[LOOP_W-1:0];
            end
            default: take_br = 1'b0;
          endcase
          upc_d = take_br ? cur_br : upc_inc;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      upc_q     <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      upc_q     <= upc_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Control store.  A write coinciding with an accepted start lands on the
  // same edge, so the first fetch already sees the new word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (store_wr) begin
      mem_q[cfg_addr] <= cfg_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy    = running;
  assign done    = (state_q == ST_DONE);
  assign cfg_err = cfg_err_q;
  assign upc     = upc_q;
  assign ctrl    = (running && (cur_cond != COND_LDC)) ? cur_ctrl : '0;

endmodule

// File: tb/tb_microprogram_sequencer.sv
// -----------------------------------------------------------------------------
// tb_microprogram_sequencer
//
// Self-checking bench for microprogram_sequencer at default parameters
// (ADDR_W=4, CTRL_W=8, LOOP_W=8, 16-bit words).  Each test loads a program,
// pushes the per-cycle outputs it expects onto exp_q, runs the program while
// recording the observed outputs onto obs_q, then compares the two queues.
// -----------------------------------------------------------------------------
module tb_microprogram_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        x1;
  logic        x2;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [3:0]  upc;
  logic [7:0]  ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] upc;
    logic [7:0] ctrl;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];

  int total;
  int bad;

  microprogram_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .x1       (x1),
    .x2       (x2),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .busy     (busy),
    .done     (done),
    .cfg_err  (cfg_err),
    .upc      (upc),
    .ctrl     (ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ctrl, cond, br, end}
  function automatic logic [15:0] mk(input logic [7:0] c, input logic [2:0] cd,
                                     input logic [3:0] b, input logic e);
    return {c, cd, b, e};
  endfunction

  function automatic obs_t ex(input logic b, input logic d, input logic er,
                              input logic [3:0] u, input logic [7:0] c);
    obs_t o;
    o.busy = b; o.done = d; o.err = er; o.upc = u; o.ctrl = c;
    return o;
  endfunction

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    obs_q.push_back(ex(busy, done, cfg_err, upc, ctrl));
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  // Pulse start, then record n cycles.  While cycle i is observed, the inputs
  // for the edge that ends cycle i are set: cfg write at we_at, abort at
  // abort_at, a stray start at start_at (0 = never).
  task automatic run(input int n, input int we_at, input int abort_at, input int start_at,
                     input logic [3:0] wa, input logic [15:0] wd);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= n; i++) begin
      sample();
      cfg_we = (i == we_at); cfg_addr = wa; cfg_data = wd;
      abort  = (i == abort_at);
      start  = (i == start_at);
      tick();
      cfg_we = 1'b0; abort = 1'b0; start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ex(0, 0, 0, 4'd0, 8'h00));
      sample();
      tick();
    end
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset got b=%b d=%b e=%b upc=%0d ctrl=%h want b=%b d=%b e=%b upc=%0d ctrl=%h",
                 o.busy, o.done, o.err, o.upc, o.ctrl, e.busy, e.done, e.err, e.upc, e.ctrl);
      end
    end
  endtask

  task automatic test_load_exec();
    logic [7:0] v;
    for (int a = 0; a < 4; a++) begin
      v = 8'(8'h11 * (a + 1));
      wr(4'(a), mk(v, 3'd0, 4'd0, a == 3));
      exp_q.push_back(ex(1, 0, 0, 4'(a), v));
    end
    exp_q.push_back(ex(0, 1, 0, 4'd3, 8'h00));
    exp_q.push_back(ex(0, 0, 0, 4'd3, 8'h00));
    run(6, 0, 0, 0, 4'd0, 16'h0);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL load_exec got b=%b d=%b e=%b upc=%0d ctrl=%h want b=%b d=%b e=%b upc=%0d ctrl=%h",
                 o.busy, o.done, o.err, o.upc, o.ctrl, e.busy, e.done, e.err, e.upc, e.ctrl);
      end
    end
  endtask

  task automatic test_branch();
    // {cond, x1, x2}
    logic [4:0] cases [9];
    logic [2:0] cd;
    logic       tk;
    logic [3:0] u3;
    cases = '{ {3'd2, 1'b1, 1'b0}, {3'd2, 1'b0, 1'b1}, {3'd3, 1'b0, 1'b0},
               {3'd3, 1'b1, 1'b0}, {3'd4, 1'b0, 1'b1}, {3'd4, 1'b1, 1'b0},
               {3'd5, 1'b0, 1'b0}, {3'd5, 1'b1, 1'b1}, {3'd1, 1'b0, 1'b0} };
    wr(4'd0, mk(8'h01, 3'd0, 4'd0, 1'b0));
    wr(4'd2, mk(8'h03, 3'd0, 4'd0, 1'b1));
    wr(4'd4, mk(8'h05, 3'd0, 4'd0, 1'b1));
    for (int k = 0; k < 9; k++) begin
      cd = cases[k][4:2];
      x1 = cases[k][1];
      x2 = cases[k][0];
      tk = (cd == 3'd1) || (cd == 3'd2 && x1) || (cd == 3'd3 && !x1) ||
           (cd == 3'd4 && x2) || (cd == 3'd5 && !x2);
      u3 = tk ? 4'd4 : 4'd2;
      wr(4'd1, mk(8'h02, cd, 4'd4, 1'b0));
      exp_q.push_back(ex(1, 0, 0, 4'd0, 8'h01));
      exp_q.push_back(ex(1, 0, 0, 4'd1, 8'h02));
      exp_q.push_back(ex(1, 0, 0, u3, tk ? 8'h05 : 8'h03));
      exp_q.push_back(ex(0, 1, 0, u3, 8'h00));
      exp_q.push_back(ex(0, 0, 0, u3, 8'h00));
      run(5, 0, 0, 0, 4'd0, 16'h0);
      while (exp_q.size() > 0) begin
        obs_t e, o;
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL branch cond=%0d x1=%b x2=%b got b=%b d=%b upc=%0d ctrl=%h want b=%b d=%b upc=%0d ctrl=%h",
                   cd, x1, x2, o.busy, o.done, o.upc, o.ctrl, e.busy, e.done, e.upc, e.ctrl);
        end
      end
    end
    x1 = 1'b0; x2 = 1'b0;
  endtask

  task automatic test_loop();
    wr(4'd0, mk(8'h03, 3'd7, 4'd0, 1'b0));
    wr(4'd1, mk(8'hA5, 3'd6, 4'd1, 1'b0));
    wr(4'd2, mk(8'h77, 3'd0, 4'd0, 1'b1));
    exp_q.push_back(ex(1, 0, 0, 4'd0, 8'h00));
    for (int i = 0; i < 4; i++) exp_q.push_back(ex(1, 0, 0, 4'd1, 8'hA5));
    exp_q.push_back(ex(1, 0, 0, 4'd2, 8'h77));
    exp_q.push_back(ex(0, 1, 0, 4'd2, 8'h00));
    exp_q.push_back(ex(0, 0, 0, 4'd2, 8'h00));
    run(8, 0, 0, 0, 4'd0, 16'h0);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL loop got b=%b d=%b upc=%0d ctrl=%h want b=%b d=%b upc=%0d ctrl=%h",
                 o.busy, o.done, o.upc, o.ctrl, e.busy, e.done, e.upc, e.ctrl);
      end
    end
    total++;
    if (dut.cnt_q !== 8'd0) begin
      bad++;
      $display("FAIL loop_cnt got %0d want 0", dut.cnt_q);
    end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int a = 0; a < 16; a++) wr(4'(a), mk(8'(8'h10 + a), 3'd0, 4'd0, a == 1));
    exp_q.push_back(ex(1, 0, 0, 4'd0, 8'h10));
    exp_q.push_back(ex(1, 0, 0, 4'd1, 8'h11));
    exp_q.push_back(ex(0, 1, 0, 4'd1, 8'h00));
    exp_q.push_back(ex(0, 0, 0, 4'd1, 8'h00));
    run(4, 0, 0, 0, 4'd0, 16'h0);
    // 0:DJNZ->3 (cnt 0 first pass)  1:LDC 1  2:JMP 14  14,15: step, 15 wraps to 0
    wr(4'd0, mk(8'h10, 3'd6, 4'd3, 1'b0));
    wr(4'd1, mk(8'h01, 3'd7, 4'd0, 1'b0));
    wr(4'd2, mk(8'h12, 3'd1, 4'd14, 1'b0));
    wr(4'd3, mk(8'h13, 3'd0, 4'd0, 1'b1));
    exp_q.push_back(ex(1, 0, 0, 4'd0,  8'h10));
    exp_q.push_back(ex(1, 0, 0, 4'd1,  8'h00));
    exp_q.push_back(ex(1, 0, 0, 4'd2,  8'h12));
    exp_q.push_back(ex(1, 0, 0, 4'd14, 8'h1E));
    exp_q.push_back(ex(1, 0, 0, 4'd15, 8'h1F));
    exp_q.push_back(ex(1, 0, 0, 4'd0,  8'h10));
    exp_q.push_back(ex(1, 0, 0, 4'd3,  8'h13));
    exp_q.push_back(ex(0, 1, 0, 4'd3,  8'h00));
    exp_q.push_back(ex(0, 0, 0, 4'd3,  8'h00));
    run(9, 0, 0, 0, 4'd0, 16'h0);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL wrap got b=%b d=%b upc=%0d ctrl=%h want b=%b d=%b upc=%0d ctrl=%h",
                 o.busy, o.done, o.upc, o.ctrl, e.busy, e.done, e.upc, e.ctrl);
      end
    end
  endtask

  task automatic test_cfg_protect();
    for (int a = 0; a < 4; a++) wr(4'(a), mk(8'(8'h11 * (a + 1)), 3'd0, 4'd0, a == 3));
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.push_back(ex(1, 0, 0, 4'd0, 8'h11));
      exp_q.push_back(ex(1, 0, 0, 4'd1, 8'h22));
      exp_q.push_back(ex(1, 0, pass == 0, 4'd2, 8'h33));
      exp_q.push_back(ex(1, 0, 0, 4'd3, 8'h44));
      exp_q.push_back(ex(0, 1, 0, 4'd3, 8'h00));
      exp_q.push_back(ex(0, 0, 0, 4'd3, 8'h00));
      // first pass: illegal write of word 2 plus a stray start, both at cycle 2
      if (pass == 0) run(6, 2, 0, 2, 4'd2, mk(8'hFF, 3'd0, 4'd0, 1'b1));
      else           run(6, 0, 0, 0, 4'd0, 16'h0);
      while (exp_q.size() > 0) begin
        obs_t e, o;
        e = exp_q.pop_front();
        o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL cfg_protect pass%0d got b=%b d=%b e=%b upc=%0d ctrl=%h want b=%b d=%b e=%b upc=%0d ctrl=%h",
                   pass, o.busy, o.done, o.err, o.upc, o.ctrl, e.busy, e.done, e.err, e.upc, e.ctrl);
        end
      end
    end
  endtask

  task automatic test_start_with_write();
    // Write of word 0 and start on the same IDLE edge: first fetch sees new word
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = mk(8'h99, 3'd0, 4'd0, 1'b1);
    start  = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    exp_q.push_back(ex(1, 0, 0, 4'd0, 8'h99));
    exp_q.push_back(ex(0, 1, 0, 4'd0, 8'h00));
    exp_q.push_back(ex(0, 0, 0, 4'd0, 8'h00));
    for (int i = 0; i < 3; i++) begin
      sample();
      tick();
    end
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL start_with_write got b=%b d=%b e=%b upc=%0d ctrl=%h want b=%b d=%b e=%b upc=%0d ctrl=%h",
                 o.busy, o.done, o.err, o.upc, o.ctrl, e.busy, e.done, e.err, e.upc, e.ctrl);
      end
    end
  endtask

  task automatic test_abort();
    for (int a = 0; a < 4; a++) wr(4'(a), mk(8'(8'h11 * (a + 1)), 3'd0, 4'd0, a == 3));
    // abort in the 2nd RUN cycle
    exp_q.push_back(ex(1, 0, 0, 4'd0, 8'h11));
    exp_q.push_back(ex(1, 0, 0, 4'd1, 8'h22));
    for (int i = 0; i < 3; i++) exp_q.push_back(ex(0, 0, 0, 4'd1, 8'h00));
    run(5, 0, 2, 0, 4'd0, 16'h0);
    // abort coinciding with the end instruction: no done
    exp_q.push_back(ex(1, 0, 0, 4'd0, 8'h11));
    exp_q.push_back(ex(1, 0, 0, 4'd1, 8'h22));
    exp_q.push_back(ex(1, 0, 0, 4'd2, 8'h33));
    exp_q.push_back(ex(1, 0, 0, 4'd3, 8'h44));
    exp_q.push_back(ex(0, 0, 0, 4'd3, 8'h00));
    exp_q.push_back(ex(0, 0, 0, 4'd3, 8'h00));
    run(6, 0, 4, 0, 4'd0, 16'h0);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL abort got b=%b d=%b upc=%0d ctrl=%h want b=%b d=%b upc=%0d ctrl=%h",
                 o.busy, o.done, o.upc, o.ctrl, e.busy, e.done, e.upc, e.ctrl);
      end
    end
  endtask

  task automatic test_reset_midrun();
    for (int a = 0; a < 4; a++) wr(4'(a), mk(8'(8'h11 * (a + 1)), 3'd0, 4'd0, a == 3));
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.push_back(ex(1, 0, 0, 4'd0, 8'h11));
    sample();
    tick();
    exp_q.push_back(ex(1, 0, 0, 4'd1, 8'h22));
    sample();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.push_back(ex(0, 0, 0, 4'd0, 8'h00));
    sample();
    tick();
    exp_q.push_back(ex(0, 0, 0, 4'd0, 8'h00));
    sample();
    // Cleared store: zero words step forward until aborted
    exp_q.push_back(ex(1, 0, 0, 4'd0, 8'h00));
    exp_q.push_back(ex(1, 0, 0, 4'd1, 8'h00));
    exp_q.push_back(ex(1, 0, 0, 4'd2, 8'h00));
    exp_q.push_back(ex(0, 0, 0, 4'd2, 8'h00));
    exp_q.push_back(ex(0, 0, 0, 4'd2, 8'h00));
    run(5, 0, 3, 0, 4'd0, 16'h0);
    while (exp_q.size() > 0) begin
      obs_t e, o;
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL reset_midrun got b=%b d=%b e=%b upc=%0d ctrl=%h want b=%b d=%b e=%b upc=%0d ctrl=%h",
                 o.busy, o.done, o.err, o.upc, o.ctrl, e.busy, e.done, e.err, e.upc, e.ctrl);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; x1 = 1'b0; x2 = 1'b0;
    cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 16'h0;
    test_reset();
    test_load_exec();
    test_branch();
    test_loop();
    test_wrap();
    test_cfg_protect();
    test_start_with_write();
    test_abort();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
